pulse_chan_bank: RTL and testbench

//  Parametrised register bank and timing core for NCH square/pulse channels.

---
 rtl/pulse_pkg.sv | 29 ++
 rtl/pulse_chan.sv | 105 ++++++++++
 rtl/pulse_chan_bank.sv | 140 ++++++++++++++
 tb/tb_pulse_chan_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared constants and types for the pulse channel bank.
//  REG_*          register index within a channel's 4-byte window
//  DAC_OFF_MASK   envelope bits that must be non-zero for the DAC to be on
//  pulse_regs_t   one channel's programmable state, sized for the widest build
package pulse_pkg;

  localparam logic [1:0] REG_DUTYLEN = 2'd0;
  localparam logic [1:0] REG_ENV     = 2'd1;
  localparam logic [1:0] REG_FLO     = 2'd2;
  localparam logic [1:0] REG_FHI     = 2'd3;

  localparam logic [7:0] DAC_OFF_MASK = 8'hF8;

  localparam int FREQ_W_MAX = 14;
  localparam int LEN_W_MAX  = 6;

  typedef struct packed {
    logic [1:0]            duty;
    logic [LEN_W_MAX-1:0]  len_load;
    logic [7:0]            env;
    logic [FREQ_W_MAX-1:0] freq;
    logic                  len_en;
  } pulse_regs_t;

  function automatic logic dac_on(input logic [7:0] env);
    return (env & DAC_OFF_MASK) != 8'h00;
  endfunction

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: registers, frequency counter, length counter.
//  clk, napu_reset   clock, synchronous active-low reset
//  wr, rsel, din     write strobe for this channel, register index, data
//  freq_tick         frequency counter enable
//  len_tick          length counter strobe
//  sweep_ld/_freq    sweep unit frequency update (channel 0 only, else tied 0)
//  sweep_kill        sweep overflow, drops the channel
//  regs              programmable state for read-back and the sweep unit
//  ftick, trig       registered one-cycle pulses
//  active            channel enabled
//  trig_evt          combinational: trigger being written this cycle
//  trig_freq         combinational: frequency the trigger loads
module pulse_chan
  import pulse_pkg::*;
#(
  parameter int FREQ_W = 11,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              napu_reset,
  input  logic              wr,
  input  logic [1:0]        rsel,
  input  logic [7:0]        din,
  input  logic              freq_tick,
  input  logic              len_tick,
  input  logic              sweep_ld,
  input  logic [FREQ_W-1:0] sweep_freq,
  input  logic              sweep_kill,
  output pulse_regs_t       regs,
  output logic              ftick,
  output logic              trig,
  output logic              active,
  output logic              trig_evt,
  output logic [FREQ_W-1:0] trig_freq
);

  localparam logic [FREQ_W-1:0] FREQ_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  pulse_regs_t       r;
  logic [FREQ_W-1:0] freq_cnt;
  logic [LEN_W-1:0]  len_cnt;

  logic wr_dl, wr_env, wr_flo, wr_fhi, len_exp, env_off_wr;

  assign wr_dl     = wr && (rsel == REG_DUTYLEN);
  assign wr_env    = wr && (rsel == REG_ENV);
  assign wr_flo    = wr && (rsel == REG_FLO);
  assign wr_fhi    = wr && (rsel == REG_FHI);
  assign trig_evt  = wr_fhi && din[7];
  // the trigger write carries the new high bits, so reload from them
  assign trig_freq = {din[FREQ_W-9:0], r.freq[7:0]};
  // a length-register write in the same cycle pre-empts expiry
  assign len_exp   = len_tick && r.len_en && (&len_cnt) && !wr_dl;
  assign env_off_wr = wr_env && !dac_on(din);
  assign regs      = r;

  always_ff @(posedge clk) begin
    if (!napu_reset) begin
      r        <= '0;
      freq_cnt <= '0;
      len_cnt  <= '0;
      ftick    <= 1'b0;
      trig     <= 1'b0;
      active   <= 1'b0;
    end else begin
      trig  <= trig_evt;
      ftick <= 1'b0;

      if (wr_dl) begin
        r.duty                <= din[7:6];
        r.len_load[LEN_W-1:0] <= din[LEN_W-1:0];
        len_cnt               <= din[LEN_W-1:0];
      end else if (len_tick && r.len_en) begin
        len_cnt <= len_cnt + LEN_ONE;
      end

      if (wr_env) r.env <= din;

      // register writes take priority over a sweep update
      if (wr_flo)        r.freq[7:0]        <= din;
      else if (wr_fhi)   r.freq[FREQ_W-1:8] <= din[FREQ_W-9:0];
      else if (sweep_ld) r.freq[FREQ_W-1:0] <= sweep_freq;

      if (wr_fhi) r.len_en <= din[6];

      if (trig_evt) begin
        freq_cnt <= trig_freq;
      end else if (freq_tick) begin
        if (&freq_cnt) begin
          freq_cnt <= r.freq[FREQ_W-1:0];
          ftick    <= 1'b1;
        end else begin
          freq_cnt <= freq_cnt + FREQ_ONE;
        end
      end

      if (trig_evt)
        active <= dac_on(r.env);
      else if (env_off_wr || !dac_on(r.env) || len_exp || sweep_kill)
        active <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_chan_bank.sv
// Register bank and timing core for NCH pulse channels.
//  clk, napu_reset  APU clock, synchronous active-low reset
//  apu_wr, din      one-cycle write strobe and data
//  cpu_rd, dout     read enable and combinational read data (FF when idle)
//  addr             [1:0] register, upper bits channel; NCH*4 is the sweep reg
//  freq_tick, len_tick, sweep_tick   timing strobes
//  ch_ftick, ch_duty, ch_env, ch_trig, ch_active   per-channel outputs
// Build option: PULSE_SWEEP_EN adds the channel-0 frequency sweep unit.
module pulse_chan_bank
  import pulse_pkg::*;
#(
  parameter  int NCH    = 2,
  parameter  int FREQ_W = 11,
  parameter  int LEN_W  = 6,
  localparam int ADDR_W = $clog2(NCH*4+1)
) (
  input  logic              clk,
  input  logic              napu_reset,
  input  logic              apu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  input  logic              freq_tick,
  input  logic              len_tick,
  input  logic              sweep_tick,
  output logic [NCH-1:0]    ch_ftick,
  output logic [2*NCH-1:0]  ch_duty,
  output logic [8*NCH-1:0]  ch_env,
  output logic [NCH-1:0]    ch_trig,
  output logic [NCH-1:0]    ch_active
);

  pulse_regs_t [NCH-1:0]             regs;
  logic [NCH-1:0][7:0]               rdata;
  logic [NCH-1:0]                    ch_sel;
  logic [NCH-1:0]                    trig_evt;
  logic [NCH-1:0][FREQ_W-1:0]        trig_freq;
  logic                              in_range, sweep_sel;
  logic                              sweep_ld, sweep_kill;
  logic [FREQ_W-1:0]                 sweep_freq;
  logic [7:0]                        sweep_rd;

  assign in_range  = addr < ADDR_W'(NCH*4);
  assign sweep_sel = addr == ADDR_W'(NCH*4);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign ch_sel[c] = in_range && (addr[ADDR_W-1:2] == (ADDR_W-2)'(c));

    pulse_chan #(.FREQ_W(FREQ_W), .LEN_W(LEN_W)) u_chan (
      .clk        (clk),
      .napu_reset (napu_reset),
      .wr         (apu_wr && ch_sel[c]),
      .rsel       (addr[1:0]),
      .din        (din),
      .freq_tick  (freq_tick),
      .len_tick   (len_tick),
      .sweep_ld   ((c == 0) && sweep_ld),
      .sweep_freq (sweep_freq),
      .sweep_kill ((c == 0) && sweep_kill),
      .regs       (regs[c]),
      .ftick      (ch_ftick[c]),
      .trig       (ch_trig[c]),
      .active     (ch_active[c]),
      .trig_evt   (trig_evt[c]),
      .trig_freq  (trig_freq[c])
    );

    assign ch_duty[2*c +: 2] = regs[c].duty;
    assign ch_env[8*c +: 8]  = regs[c].env;

    // write-only and unimplemented bits read as 1
    assign rdata[c] = (addr[1:0] == REG_DUTYLEN) ? {regs[c].duty, 6'h3F} :
                      (addr[1:0] == REG_ENV)     ? regs[c].env :
                      (addr[1:0] == REG_FLO)     ? 8'hFF :
                                                   {1'b1, regs[c].len_en, 6'h3F};
  end

`ifdef PULSE_SWEEP_EN
  logic [2:0]        sw_period, sw_shift, sw_cnt;
  logic              sw_neg, sw_fire, sw_ovf;
  logic [FREQ_W-1:0] shadow;
  logic [FREQ_W:0]   nf;

  assign nf = sw_neg ? ({1'b0, shadow} - {1'b0, shadow >> sw_shift})
                     : ({1'b0, shadow} + {1'b0, shadow >> sw_shift});
  // a count of 1 (or 0 after reset) reaches zero on this tick
  assign sw_fire    = sweep_tick && (sw_period != 3'd0) && (sw_cnt <= 3'd1);
  assign sw_ovf     = nf[FREQ_W];
  assign sweep_kill = sw_fire && sw_ovf;
  assign sweep_ld   = sw_fire && !sw_ovf && (sw_shift != 3'd0);
  assign sweep_freq = nf[FREQ_W-1:0];
  assign sweep_rd   = {1'b1, sw_period, sw_neg, sw_shift};

  always_ff @(posedge clk) begin
    if (!napu_reset) begin
      sw_period <= '0;
      sw_neg    <= 1'b0;
      sw_shift  <= '0;
      sw_cnt    <= '0;
      shadow    <= '0;
    end else begin
      if (apu_wr && sweep_sel) begin
        sw_period <= din[6:4];
        sw_neg    <= din[3];
        sw_shift  <= din[2:0];
      end
      if (trig_evt[0]) begin
        shadow <= trig_freq[0];
        sw_cnt <= sw_period;
      end else if (sweep_tick && (sw_period != 3'd0)) begin
        if (sw_fire) begin
          sw_cnt <= sw_period;
          if (sweep_ld) shadow <= sweep_freq;
        end else begin
          sw_cnt <= sw_cnt - 3'd1;
        end
      end
    end
  end
`else
  assign sweep_ld   = 1'b0;
  assign sweep_kill = 1'b0;
  assign sweep_freq = '0;
  assign sweep_rd   = 8'hFF;
`endif

  always_comb begin
    dout = 8'hFF;
    if (cpu_rd) begin
      for (int c = 0; c < NCH; c++)
        if (ch_sel[c]) dout = rdata[c];
      if (sweep_sel) dout = sweep_rd;
    end
  end

  logic unused_sink;
  assign unused_sink = ^{regs, trig_evt, trig_freq, sweep_tick};

endmodule

// File: tb/tb_pulse_chan_bank.sv
module tb_pulse_chan_bank;

  logic       clk = 1'b0;
  logic       napu_reset, apu_wr, cpu_rd, freq_tick, len_tick, sweep_tick;
  logic [3:0] addr;
  logic [7:0] din, dout;
  logic [1:0] ch_ftick, ch_trig, ch_active;
  logic [3:0] ch_duty;
  logic [15:0] ch_env;

  int npass = 0, nchk = 0, n;

  pulse_chan_bank #(.NCH(2), .FREQ_W(11), .LEN_W(6)) dut (
    .clk(clk), .napu_reset(napu_reset), .apu_wr(apu_wr), .cpu_rd(cpu_rd),
    .addr(addr), .din(din), .dout(dout), .freq_tick(freq_tick),
    .len_tick(len_tick), .sweep_tick(sweep_tick), .ch_ftick(ch_ftick),
    .ch_duty(ch_duty), .ch_env(ch_env), .ch_trig(ch_trig), .ch_active(ch_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr = a; din = d; apu_wr = 1'b1;
    tick();
    apu_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic en, input logic [7:0] exp, input string tag);
    addr = a; cpu_rd = en;
    #1;
    chk(tag, {24'h0, dout}, {24'h0, exp});
    cpu_rd = 1'b0;
  endtask

  // edges until ch_ftick[b] seen; -1 if the bound expires
  task automatic wait_ftick(input int b, input int bound, output int cnt);
    cnt = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (ch_ftick[b]) begin
        cnt = k;
        break;
      end
    end
  endtask

  logic [7:0] rst_map [4];
  logic [7:0] sw_rst;

  initial begin
    rst_map[0] = 8'h3F; rst_map[1] = 8'h00; rst_map[2] = 8'hFF; rst_map[3] = 8'hBF;
`ifdef PULSE_SWEEP_EN
    sw_rst = 8'h80;
`else
    sw_rst = 8'hFF;
`endif
    napu_reset = 1'b0; apu_wr = 1'b0; cpu_rd = 1'b0; freq_tick = 1'b0;
    len_tick = 1'b0; sweep_tick = 1'b0; addr = '0; din = '0;
    repeat (2) tick();
    chk("rst_active", {30'h0, ch_active}, 32'h0);
    chk("rst_trig",   {30'h0, ch_trig},   32'h0);
    chk("rst_ftick",  {30'h0, ch_ftick},  32'h0);
    chk("rst_duty",   {28'h0, ch_duty},   32'h0);
    chk("rst_env",    {16'h0, ch_env},    32'h0);
    napu_reset = 1'b1;
    tick();

    // reset read-back map
    for (int a = 0; a < 8; a++) rd(4'(a), 1'b1, rst_map[a % 4], $sformatf("rst_rd%0d", a));
    rd(4'd8, 1'b1, sw_rst, "rst_rd_sweep");
    rd(4'd9, 1'b1, 8'hFF, "rd_oob");
    rd(4'd1, 1'b0, 8'hFF, "rd_disabled");

    // channel 1 trigger and frequency counter
    wr(4'd5, 8'hF0);
    wr(4'd6, 8'hFE);
    wr(4'd7, 8'h87);
    chk("c1_trig",   {30'h0, ch_trig},   32'h2);
    chk("c1_active", {30'h0, ch_active}, 32'h2);
    chk("c1_env",    {24'h0, ch_env[15:8]}, 32'hF0);
    tick();
    chk("c1_trig_end", {30'h0, ch_trig}, 32'h0);
    freq_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("c1_ftick%0d", i), {31'h0, ch_ftick[1]}, 32'(i % 2));
    end

    // trigger concurrent with a wrapping freq_tick: reload wins, no ftick
    tick();
    wr(4'd7, 8'h80);
    chk("trig_vs_wrap_ftick", {31'h0, ch_ftick[1]}, 32'h0);
    chk("trig_vs_wrap_trig",  {31'h0, ch_trig[1]},  32'h1);
    wait_ftick(1, 4000, n);
    chk("reload_to_freq_0fe", n, 32'd1794);
    freq_tick = 1'b0;

    // length counter on channel 0
    wr(4'd1, 8'hF0);
    wr(4'd0, 8'h3E);
    wr(4'd3, 8'hC0);
    chk("c0_trig_active", {31'h0, ch_active[0]}, 32'h1);
    len_tick = 1'b1;
    tick();
    chk("len_3f", {31'h0, ch_active[0]}, 32'h1);
    tick();
    chk("len_expire", {31'h0, ch_active[0]}, 32'h0);
    len_tick = 1'b0;
    wr(4'd3, 8'hC0);
    wr(4'd0, 8'h3F);
    len_tick = 1'b1;
    wr(4'd0, 8'h3E);
    chk("len_wr_wins", {31'h0, ch_active[0]}, 32'h1);
    tick();
    chk("len_3f_b", {31'h0, ch_active[0]}, 32'h1);
    tick();
    chk("len_expire_b", {31'h0, ch_active[0]}, 32'h0);
    len_tick = 1'b0;
    wr(4'd0, 8'h3F);
    len_tick = 1'b1;
    wr(4'd3, 8'hC0);
    chk("trig_plus_expire", {31'h0, ch_active[0]}, 32'h1);
    tick();
    chk("after_trig_expire", {31'h0, ch_active[0]}, 32'h1);
    len_tick = 1'b0;
    wr(4'd3, 8'h80);
    wr(4'd0, 8'h3E);
    len_tick = 1'b1;
    repeat (4) tick();
    chk("len_disabled", {31'h0, ch_active[0]}, 32'h1);
    len_tick = 1'b0;
    rd(4'd3, 1'b1, 8'hBF, "rd_r3_len_en0");
    wr(4'd0, 8'hBE);
    rd(4'd0, 1'b1, 8'hBF, "rd_r0_duty2");
    chk("duty_out", {30'h0, ch_duty[1:0]}, 32'h2);
    wr(4'd3, 8'h40);
    rd(4'd3, 1'b1, 8'hFF, "rd_r3_len_en1");

    // DAC off
    wr(4'd1, 8'h00);
    chk("dac_off_drop", {31'h0, ch_active[0]}, 32'h0);
    chk("dac_off_env",  {24'h0, ch_env[7:0]}, 32'h0);
    wr(4'd1, 8'h07);
    wr(4'd3, 8'h80);
    chk("dac_off_trig",   {31'h0, ch_trig[0]},   32'h1);
    chk("dac_off_active", {30'h0, ch_active},    32'h2);
    rd(4'd1, 1'b1, 8'h07, "rd_env07");

`ifdef PULSE_SWEEP_EN
    wr(4'd1, 8'hF0);
    wr(4'd8, 8'h11);
    rd(4'd8, 1'b1, 8'h91, "rd_sweep");
    wr(4'd2, 8'h00);
    wr(4'd3, 8'h87);
    chk("sw_trig_active", {31'h0, ch_active[0]}, 32'h1);
    sweep_tick = 1'b1;
    tick();
    sweep_tick = 1'b0;
    chk("sw_overflow_drop", {31'h0, ch_active[0]}, 32'h0);
    wr(4'd8, 8'h19);
    wr(4'd3, 8'h87);
    sweep_tick = 1'b1;
    tick();
    sweep_tick = 1'b0;
    chk("sw_negate_active", {31'h0, ch_active[0]}, 32'h1);
    freq_tick = 1'b1;
    wait_ftick(0, 4000, n);
    chk("sw_first_wrap", n, 32'd256);
    wait_ftick(0, 4000, n);
    chk("sw_freq_380_period", n, 32'd1152);
    freq_tick = 1'b0;
`else
    wr(4'd8, 8'h55);
    rd(4'd8, 1'b1, 8'hFF, "rd_sweep_absent");
    chk("sweep_wr_ignored", {30'h0, ch_active}, 32'h2);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
